lot_occupancy: RTL

LOT_OCCUPANCY -- requirements
Module: lot_occupancy

---
 rtl/lot_occupancy.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/lot_occupancy.sv
// rtl/lot_occupancy.sv - parking lot occupancy counter fed by debounced
// outer/inner beam sensors on each gate lane.
module lot_occupancy #(
  parameter int LANES    = 2,
  parameter int CAPACITY = 25,
  parameter int DEBOUNCE = 2,
  localparam int CNT_W   = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LANES-1:0] outer,
  input  logic [LANES-1:0] inner,
  input  logic             clr,
  output logic [LANES-1:0] enter,
  output logic [LANES-1:0] exit,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int NB = 2 * LANES;
  localparam int SW = CNT_W + 6;
  localparam logic [3:0]           DB_LAST = 4'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0]     CAP     = CNT_W'(CAPACITY);
  localparam logic signed [SW-1:0] CAP_S   = SW'(CAPACITY);

  typedef enum logic [2:0] {IDLE, OUT_B, BOTH, IN_B, AMBIG} state_t;

  // Sensor bit k is outer[k]; bit LANES+k is inner[k].
  logic [NB-1:0]        sync1, sync2, filt;
  logic [3:0]           db_cnt [NB];
  state_t               state [LANES];
  logic [1:0]           oi [LANES];
  logic [LANES-1:0]     ent_ev, ext_ev;
  logic [3:0]           n_ent, n_ext;
  logic signed [SW-1:0] sum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      filt  <= '0;
      for (int b = 0; b < NB; b++) db_cnt[b] <= '0;
    end else begin
      sync1 <= {inner, outer};
      sync2 <= sync1;
      for (int b = 0; b < NB; b++) begin
        if (sync2[b] == filt[b]) begin
          db_cnt[b] <= '0;
        end else if (db_cnt[b] == DB_LAST) begin
          filt[b]   <= sync2[b];
          db_cnt[b] <= '0;
        end else begin
          db_cnt[b] <= db_cnt[b] + 4'd1;
        end
      end
    end
  end

  // Events are decoded from the current state so the counter and the pulses
  // commit on the same edge as the lane transition.
  always_comb begin
    ent_ev = '0;
    ext_ev = '0;
    n_ent  = '0;
    n_ext  = '0;
    for (int k = 0; k < LANES; k++) begin
      oi[k] = {filt[k], filt[LANES+k]};
      if (state[k] == BOTH && oi[k] == 2'b01) ent_ev[k] = 1'b1;
      if (state[k] == BOTH && oi[k] == 2'b10) ext_ev[k] = 1'b1;
      n_ent = n_ent + {3'b000, ent_ev[k]};
      n_ext = n_ext + {3'b000, ext_ev[k]};
    end
    sum = $signed({{(SW-CNT_W){1'b0}}, occupancy})
        + $signed({{(SW-4){1'b0}}, n_ent})
        - $signed({{(SW-4){1'b0}}, n_ext});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < LANES; k++) state[k] <= IDLE;
      enter <= '0;
      exit  <= '0;
    end else begin
      enter <= ent_ev;
      exit  <= ext_ev;
      for (int k = 0; k < LANES; k++) begin
        unique case (state[k])
          IDLE: begin
            if (oi[k] == 2'b10)      state[k] <= OUT_B;
            else if (oi[k] == 2'b01) state[k] <= IN_B;
            else if (oi[k] == 2'b11) state[k] <= AMBIG;
          end
          OUT_B: begin
            if (oi[k] == 2'b00)      state[k] <= IDLE;
            else if (oi[k] == 2'b11) state[k] <= BOTH;
            else if (oi[k] == 2'b01) state[k] <= AMBIG;
          end
          IN_B: begin
            if (oi[k] == 2'b00)      state[k] <= IDLE;
            else if (oi[k] == 2'b11) state[k] <= BOTH;
            else if (oi[k] == 2'b10) state[k] <= AMBIG;
          end
          BOTH: begin
            if (oi[k] == 2'b01)      state[k] <= IN_B;
            else if (oi[k] == 2'b10) state[k] <= OUT_B;
            else if (oi[k] == 2'b00) state[k] <= AMBIG;
          end
          AMBIG: begin
            if (oi[k] == 2'b00) state[k] <= IDLE;
          end
          default: state[k] <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occupancy <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      occupancy <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (sum > CAP_S) begin
      occupancy <= CAP;
      overflow  <= 1'b1;
    end else if (sum < 0) begin
      occupancy <= '0;
      underflow <= 1'b1;
    end else begin
      occupancy <= sum[CNT_W-1:0];
    end
  end

  assign full  = (occupancy == CAP);
  assign empty = (occupancy == '0);

endmodule
